// File: rtl/wash_timer_ctrl_if.sv
// Handshake bundle between the washing-machine FSM and its timing controller.
// master = machine side (drives actuators/requests), slave = timer side.
interface wash_timer_ctrl_if;
  logic       start;
  logic       doorclose;
  logic [1:0] prog;
  logic       fillvalve_on;
  logic       motor_on;
  logic       drainvalve_on;
  logic       done;
  logic       filled;
  logic       cycletime_out;
  logic       drained;
  logic       spintime_out;
  logic       busy;
  logic [2:0] phase;
  logic       abort;

  modport master (
    output start, doorclose, prog, fillvalve_on, motor_on, drainvalve_on, done,
    input  filled, cycletime_out, drained, spintime_out, busy, phase, abort
  );

  modport slave (
    input  start, doorclose, prog, fillvalve_on, motor_on, drainvalve_on, done,
    output filled, cycletime_out, drained, spintime_out, busy, phase, abort
  );
endinterface

// File: rtl/wash_timer_ctrl.sv
// Washing-machine timing/sequencing controller. Follows the machine's
// actuators, counts enabled cycles per phase and returns one-cycle
// completion strobes. Run: FILL WASH DRAIN FILL WASH DRAIN SPIN, FINISH.
module wash_timer_ctrl #(
  parameter int CNT_W   = 10,
  parameter int FILL_T  = 20,
  parameter int WASH_T  = 100,
  parameter int DRAIN_T = 20,
  parameter int SPIN_T  = 50
) (
  input logic              clk,
  input logic              rst,
  wash_timer_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    WASH   = 3'd2,
    DRAIN  = 3'd3,
    SPIN   = 3'd4,
    FINISH = 3'd5
  } state_t;

  typedef struct packed {
    logic filled;
    logic cto;
    logic drained;
    logic spt;
    logic abort;
  } stb_t;

  localparam logic [CNT_W-1:0] FILL_LEN  = CNT_W'(FILL_T);
  localparam logic [CNT_W-1:0] WASH_LEN1 = CNT_W'(WASH_T);
  localparam logic [CNT_W-1:0] WASH_LEN2 = CNT_W'(2 * WASH_T);
  localparam logic [CNT_W-1:0] WASH_LEN3 = CNT_W'(3 * WASH_T);
  localparam logic [CNT_W-1:0] DRAIN_LEN = CNT_W'(DRAIN_T);
  localparam logic [CNT_W-1:0] SPIN_LEN1 = CNT_W'(SPIN_T);
  localparam logic [CNT_W-1:0] SPIN_LEN2 = CNT_W'(2 * SPIN_T);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len;
  logic             rinse;
  logic [1:0]       prog_q;
  logic             en;
  logic             last;
  logic             busy_q;
  stb_t             stb;

  // Phase length from the latched program; 3 behaves like normal.
  always_comb begin
    len = FILL_LEN;
    case (state)
      FILL:  len = FILL_LEN;
      WASH:  len = (prog_q == 2'd0) ? WASH_LEN1 :
                   (prog_q == 2'd2) ? WASH_LEN3 : WASH_LEN2;
      DRAIN: len = DRAIN_LEN;
      SPIN:  len = (prog_q == 2'd0) ? SPIN_LEN1 : SPIN_LEN2;
      default: len = FILL_LEN;
    endcase
  end

  // Which actuator lets the current phase's counter advance.
  always_comb begin
    en = 1'b0;
    case (state)
      FILL:        en = bus.fillvalve_on;
      WASH:        en = bus.motor_on;
      DRAIN, SPIN: en = bus.drainvalve_on;
      default:     en = 1'b0;
    endcase
  end

  assign last = en && (cnt == len - ONE);

  // Sequencer: state, counter, rinse flag, program latch and registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rinse  <= 1'b0;
      prog_q <= 2'd0;
      busy_q <= 1'b0;
      stb    <= '0;
    end else begin
      stb <= '0;
      case (state)
        IDLE: begin
          if (bus.start && bus.doorclose) begin
            prog_q <= bus.prog;
            rinse  <= 1'b0;
            cnt    <= '0;
            state  <= FILL;
            busy_q <= 1'b1;
          end
        end
        FINISH: begin
          if (bus.done) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        FILL, WASH, DRAIN, SPIN: begin
          // Door opening wins over a completion landing on the same edge.
          if (!bus.doorclose) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            cnt       <= '0;
            rinse     <= 1'b0;
            stb.abort <= 1'b1;
          end else if (last) begin
            cnt <= '0;
            case (state)
              FILL: begin
                stb.filled <= 1'b1;
                state      <= WASH;
              end
              WASH: begin
                stb.cto <= 1'b1;
                state   <= DRAIN;
              end
              DRAIN: begin
                stb.drained <= 1'b1;
                if (rinse) begin
                  state <= SPIN;
                end else begin
                  rinse <= 1'b1;
                  state <= FILL;
                end
              end
              default: begin
                stb.spt <= 1'b1;
                state   <= FINISH;
              end
            endcase
          end else if (en) begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          // Unreachable encodings fall back to idle.
          state  <= IDLE;
          busy_q <= 1'b0;
          cnt    <= '0;
          rinse  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.filled        = stb.filled;
  assign bus.cycletime_out = stb.cto;
  assign bus.drained       = stb.drained;
  assign bus.spintime_out  = stb.spt;
  assign bus.abort         = stb.abort;
  assign bus.busy          = busy_q;
  assign bus.phase         = state;

  // Strobes never overlap, and an abort always lands in IDLE.
  a_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(stb));
  a_abort:  assert property (@(posedge clk) disable iff (!rst) stb.abort |-> state == IDLE);

endmodule

// File: tb/tb_wash_timer_ctrl.sv
// Bench for wash_timer_ctrl: directed vector table, scripted corner cases and
// randomized traffic compared against a run-plan reference model.
module tb_wash_timer_ctrl;
  localparam int CNT_W = 10, FILL_T = 2, WASH_T = 4, DRAIN_T = 2, SPIN_T = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passes = 0;
  int   tcyc   = 0;

  wash_timer_ctrl_if bus ();

  wash_timer_ctrl #(.CNT_W(CNT_W), .FILL_T(FILL_T), .WASH_T(WASH_T),
                    .DRAIN_T(DRAIN_T), .SPIN_T(SPIN_T)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A run is a fixed plan of 7 timed phases; each phase owns a budget of
  // enabled cycles that drains to zero. Strobe codes: 1 fill, 2 wash, 3 drain,
  // 4 spin, matching the phase numbers.
  typedef struct {
    bit       active;
    bit       fin;
    int       idx;
    int       left;
    int       prog;
    bit [4:0] stb;  // {abort, spin, drain, wash, fill}
  } mdl_t;

  mdl_t m;

  function automatic int plan(int i);
    case (i)
      0, 3:    return 1;
      1, 4:    return 2;
      2, 5:    return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int dur(int ph, int p);
    case (ph)
      1:       return FILL_T;
      2:       return (p == 0) ? WASH_T : (p == 2) ? 3 * WASH_T : 2 * WASH_T;
      3:       return DRAIN_T;
      default: return (p == 0) ? SPIN_T : 2 * SPIN_T;
    endcase
  endfunction

  function automatic mdl_t m_zero();
    mdl_t z;
    z.active = 0; z.fin = 0; z.idx = 0; z.left = 0; z.prog = 0; z.stb = '0;
    return z;
  endfunction

  function automatic mdl_t step(mdl_t cur, bit st, bit dc, int p, bit fv, bit mo, bit dv, bit dn);
    mdl_t n = cur;
    int   ph;
    bit   en;
    n.stb = '0;
    if (cur.fin) begin
      if (dn) n.fin = 0;
    end else if (!cur.active) begin
      if (st && dc) begin
        n.active = 1; n.idx = 0; n.prog = p; n.left = dur(1, p);
      end
    end else if (!dc) begin
      n.active = 0;
      n.stb    = 5'b10000;
    end else begin
      ph = plan(cur.idx);
      en = (ph == 1) ? fv : (ph == 2) ? mo : dv;
      if (en) begin
        n.left = cur.left - 1;
        if (n.left == 0) begin
          n.stb[ph-1] = 1'b1;
          n.idx = cur.idx + 1;
          if (n.idx == 7) begin
            n.active = 0;
            n.fin    = 1;
          end else begin
            n.left = dur(plan(n.idx), cur.prog);
          end
        end
      end
    end
    return n;
  endfunction

  // Model state update on the same edges as the DUT.
  always @(posedge clk or negedge rst) begin
    if (!rst) m <= m_zero();
    else m <= step(m, bus.start, bus.doorclose, int'(bus.prog), bus.fillvalve_on,
                   bus.motor_on, bus.drainvalve_on, bus.done);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, tcyc);
  endtask

  function automatic int dut_vec();
    return {bus.phase, bus.busy, bus.abort, bus.spintime_out, bus.drained,
            bus.cycletime_out, bus.filled};
  endfunction

  function automatic int mdl_vec();
    int ph;
    ph = m.active ? plan(m.idx) : (m.fin ? 5 : 0);
    return {ph[2:0], (m.active | m.fin), m.stb};
  endfunction

  // One clock; outputs sampled 1 time unit after the edge and checked against the model.
  task automatic cyc();
    @(posedge clk);
    #1;
    tcyc++;
    chk("model", dut_vec(), mdl_vec());
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.doorclose = 1; bus.prog = 2'd0; bus.done = 0;
    bus.fillvalve_on = 0; bus.motor_on = 0; bus.drainvalve_on = 0;
  endtask

  // Machine behaviour: open exactly the actuator the current phase needs.
  task automatic drive_machine();
    bus.fillvalve_on  = (bus.phase == 3'd1);
    bus.motor_on      = (bus.phase == 3'd2);
    bus.drainvalve_on = (bus.phase == 3'd3) || (bus.phase == 3'd4);
  endtask

  function automatic int strobe_code();
    if (bus.filled)        return 1;
    if (bus.cycletime_out) return 2;
    if (bus.drained)       return 3;
    if (bus.spintime_out)  return 4;
    return 0;
  endfunction

  // Complete run with the machine attached; checks strobe order and the cycle
  // offset of each strobe from the start edge. Optional pause in the first WASH.
  task automatic full_run(input string nm, input int p, input bit midprog, input int pause);
    int ev[$];
    int tev[$];
    int t0, pz, wen, exp_t;
    idle_inputs();
    bus.start = 1; bus.prog = p[1:0];
    cyc();
    t0 = tcyc;
    chk({nm, "_start_phase"}, int'(bus.phase), 1);
    bus.start = 0;
    if (midprog) bus.prog = 2'd0;
    pz = pause; wen = 0;
    for (int k = 0; k < 400 && bus.phase != 3'd5; k++) begin
      drive_machine();
      if (bus.phase == 3'd2 && ev.size() == 1) begin
        if (wen == 2 && pz > 0) begin
          bus.motor_on = 0;
          pz--;
        end else begin
          wen++;
        end
      end
      cyc();
      if (strobe_code() != 0) begin
        ev.push_back(strobe_code());
        tev.push_back(tcyc - t0);
      end
    end
    chk({nm, "_reach_finish"}, int'(bus.phase), 5);
    chk({nm, "_nstrobes"}, ev.size(), 7);
    exp_t = 0;
    for (int i = 0; i < 7 && i < ev.size(); i++) begin
      exp_t += dur(plan(i), (p == 3) ? 1 : p);
      if (i == 1) exp_t += pause;
      chk({nm, "_order"}, ev[i], plan(i));
      chk({nm, "_time"}, tev[i], exp_t);
    end
    drive_machine();
    bus.done = 1;
    cyc();
    bus.done = 0;
    chk({nm, "_done_phase"}, int'(bus.phase), 0);
    chk({nm, "_done_busy"}, int'(bus.busy), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit       st, dc;
    bit [1:0] p;
    bit       fv, mo, dv, dn;
    bit [2:0] ph;
    bit [5:0] o;  // {busy, abort, spin, drain, wash, fill}
  } vec_t;

  vec_t tbl[17];

  initial begin
    int ndr;
    bit seen;
    // st dc p fv mo dv dn | phase {busy,abort,spt,drn,cto,fil}
    tbl[0]  = '{0, 1, 0, 0, 0, 0, 0, 3'd0, 6'b000000};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 3'd0, 6'b000000};  // start with door open
    tbl[2]  = '{1, 1, 0, 0, 0, 0, 0, 3'd1, 6'b100000};
    tbl[3]  = '{0, 1, 0, 1, 0, 0, 0, 3'd1, 6'b100000};
    tbl[4]  = '{0, 0, 0, 1, 0, 0, 0, 3'd0, 6'b010000};  // abort on completing cycle
    tbl[5]  = '{0, 1, 0, 0, 0, 0, 0, 3'd0, 6'b000000};
    tbl[6]  = '{1, 1, 0, 0, 0, 0, 0, 3'd1, 6'b100000};
    tbl[7]  = '{0, 1, 0, 1, 0, 0, 0, 3'd1, 6'b100000};
    tbl[8]  = '{0, 1, 0, 0, 0, 0, 0, 3'd1, 6'b100000};  // fill paused
    tbl[9]  = '{0, 1, 0, 1, 0, 0, 0, 3'd2, 6'b100001};
    tbl[10] = '{1, 1, 2, 0, 1, 0, 0, 3'd2, 6'b100000};  // start/prog ignored
    tbl[11] = '{0, 1, 0, 0, 1, 0, 0, 3'd2, 6'b100000};
    tbl[12] = '{0, 1, 0, 0, 1, 0, 0, 3'd2, 6'b100000};
    tbl[13] = '{0, 1, 0, 0, 1, 0, 0, 3'd3, 6'b100010};
    tbl[14] = '{0, 1, 0, 0, 0, 1, 0, 3'd3, 6'b100000};
    tbl[15] = '{0, 1, 0, 0, 0, 1, 0, 3'd1, 6'b100100};  // first drain -> rinse fill
    tbl[16] = '{0, 1, 0, 0, 0, 0, 0, 3'd1, 6'b100000};

    idle_inputs();
    #12;
    chk("reset_outputs", dut_vec(), 0);
    @(negedge clk);
    rst = 1;

    for (int i = 0; i < 17; i++) begin
      bus.start = tbl[i].st; bus.doorclose = tbl[i].dc; bus.prog = tbl[i].p;
      bus.fillvalve_on = tbl[i].fv; bus.motor_on = tbl[i].mo;
      bus.drainvalve_on = tbl[i].dv; bus.done = tbl[i].dn;
      cyc();
      chk($sformatf("vec%0d", i),
          {bus.phase, bus.busy, bus.abort, bus.spintime_out, bus.drained,
           bus.cycletime_out, bus.filled},
          {tbl[i].ph, tbl[i].o});
    end

    // clean restart
    idle_inputs();
    #2 rst = 0;
    @(posedge clk); #1 rst = 1;

    full_run("quick", 0, 0, 0);
    full_run("heavy", 2, 1, 0);
    full_run("prog3", 3, 0, 0);
    full_run("pause", 0, 0, 5);

    // door opens during the second DRAIN
    idle_inputs();
    bus.start = 1;
    cyc();
    bus.start = 0;
    ndr = 0; seen = 0;
    for (int k = 0; k < 200 && ndr < 2; k++) begin
      drive_machine();
      cyc();
      if (bus.phase == 3'd3 && !seen) ndr++;
      seen = (bus.phase == 3'd3);
    end
    chk("abort_reach_drain2", ndr, 2);
    drive_machine();
    cyc();
    drive_machine();
    bus.doorclose = 0;
    cyc();
    chk("abort_strobe", int'(bus.abort), 1);
    chk("abort_no_drained", int'(bus.drained), 0);
    chk("abort_phase", int'(bus.phase), 0);
    idle_inputs();
    cyc();
    chk("abort_one_cycle", int'(bus.abort), 0);
    full_run("after_abort", 1, 0, 0);

    // asynchronous reset mid-SPIN
    idle_inputs();
    bus.start = 1; bus.prog = 2'd1;
    cyc();
    bus.start = 0;
    for (int k = 0; k < 200 && bus.phase != 3'd4; k++) begin
      drive_machine();
      cyc();
    end
    chk("rst_reach_spin", int'(bus.phase), 4);
    drive_machine();
    cyc();
    #2 rst = 0;
    #1;
    chk("rst_async_outputs", dut_vec(), 0);
    @(posedge clk); #1 rst = 1;
    idle_inputs();
    bus.doorclose = 0; bus.start = 1;
    cyc();
    chk("rst_start_door_open", int'(bus.phase), 0);
    chk("rst_busy", int'(bus.busy), 0);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      bus.start         = ($urandom_range(5) == 0);
      bus.doorclose     = ($urandom_range(60) != 0);
      bus.prog          = 2'($urandom_range(3));
      bus.fillvalve_on  = ($urandom_range(3) != 0);
      bus.motor_on      = ($urandom_range(3) != 0);
      bus.drainvalve_on = ($urandom_range(3) != 0);
      bus.done          = ($urandom_range(3) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/wash_timer_ctrl.md
# wash_timer_ctrl

Timing and sequencing controller for the washing-machine FSM. Watches the machine's actuator outputs (fillvalve_on, motor_on, drainvalve_on), runs per-phase duration counters, and returns the sensor/timeout strobes the machine waits on: filled, cycletime_out, drained and spintime_out. Wash and spin durations come from a program selected at start. The block replaces the external sensors and timers in simulation and in timer-only builds.

## Interface
- CNT_W, 10, duration counter width
- FILL_T, 20, enabled cycles to fill
- WASH_T, 100, base wash duration in cycles
- DRAIN_T, 20, enabled cycles to drain
- SPIN_T, 50, base spin duration in cycles
- Constraint: 3*WASH_T and 2*SPIN_T must be < 2**CNT_W; all T values must be ≥ 1.

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  start request, same signal the machine sees
- doorclose  in  1  door closed
- prog  in  2  program: 0 quick, 1 normal, 2 heavy, 3 treated as normal
- fillvalve_on  in  1  machine's fill valve output
- motor_on  in  1  machine's motor output
- drainvalve_on  in  1  machine's drain valve output
- done  in  1  machine's done output
- filled  out  1  one-cycle strobe: fill complete
- cycletime_out  out  1  one-cycle strobe: wash/rinse time elapsed
- drained  out  1  one-cycle strobe: drain complete
- spintime_out  out  1  one-cycle strobe: spin time elapsed
- busy  out  1  high in every state except IDLE
- phase  out  3  current state encoding
- abort  out  1  one-cycle strobe: run cancelled because the door opened

## Operation

**States and `phase` encoding:** IDLE=0, FILL=1, WASH=2, DRAIN=3, SPIN=4, FINISH=5.

**Start and program latch**
- IDLE: when start=1 and doorclose=1, latch prog into prog_q, clear rinse, go to FILL.

**Phase durations (len)**
- FILL: FILL_T.
- WASH: WASH_T for prog_q=0, 2*WASH_T for prog_q=1 or 3, 3*WASH_T for prog_q=2.
- DRAIN: DRAIN_T.
- SPIN: SPIN_T for prog_q=0, otherwise 2*SPIN_T.

**Phase enables (en)**
- FILL: fillvalve_on.
- WASH: motor_on.
- DRAIN and SPIN: drainvalve_on.

**Counter**
- cnt clears to 0 on entry to each timed state.
- cnt increments on each cycle with en=1; it holds while en=0 (pause, no restart).

**Phase completion**
- Completion occurs on a cycle where en=1 and cnt==len-1.
- At that clock edge, the phase's strobe is registered high for exactly one cycle and the state advances.

**Transitions on completion**
- FILL → WASH, strobe filled.
- WASH → DRAIN, strobe cycletime_out.
- DRAIN with rinse=0 → FILL and set rinse=1, strobe drained.
- DRAIN with rinse=1 → SPIN, strobe drained.
- SPIN → FINISH, strobe spintime_out.

**Finish**
- FINISH holds until done=1, then goes to IDLE.
- A run therefore has 7 timed phases: FILL, WASH, DRAIN, FILL, WASH, DRAIN, SPIN.

**Abort**
- In any state other than IDLE or FINISH, doorclose=0 forces IDLE on the next edge.
- abort strobes for one cycle, no other strobe fires that cycle, and cnt and rinse clear.
- Abort has priority over a completion on the same cycle.

**Other rules**
- start is ignored outside IDLE.
- prog changes after the latch have no effect on the current run.
- All strobes are mutually exclusive.

## Timing
- **Reset:** state=IDLE, cnt=0, rinse=0, prog_q=0. filled, cycletime_out, drained, spintime_out, abort, busy all 0; phase=0.
- **Outputs:** all registered, no combinational path from inputs to outputs.
- **Start latency:** start=1 and doorclose=1 sampled at edge k gives busy=1 and phase=1 from edge k.
- **Strobe latency:** if en is high continuously from cycle c, the strobe is high in cycle c+len, and phase has already advanced in that same cycle.
- **Reset mid-run:** returns to the reset state immediately and asynchronously; a strobe in flight is dropped.

## Test plan
- **Quick run:** prog=0, FILL_T=2, WASH_T=4, DRAIN_T=2, SPIN_T=3, machine model attached. Required: strobe order filled, cycletime_out, drained, filled, cycletime_out, drained, spintime_out, each exactly one cycle. WASH lasts 4 enabled cycles; SPIN lasts 3. After done, phase=0 and busy=0.
- **Heavy program:** prog=2, WASH_T=4. Required: cycletime_out 12 enabled cycles after WASH entry and SPIN lasts 6. Driving prog=0 mid-run changes nothing.
- **Pause:** in WASH, drop motor_on for 5 cycles after cnt=2. Required: cnt holds at 2, and cycletime_out arrives 5 cycles later than the uninterrupted run.
- **Door abort:** doorclose=0 during the second DRAIN. Required: abort=1 for one cycle, then phase=0, rinse=0, and no drained strobe. A following start runs all 7 phases again.
- **Simultaneous abort and completion:** doorclose=0 on the same cycle FILL completes. Required: abort=1, filled=0, state IDLE.
- **Reset mid-SPIN:** assert rst=0 mid-SPIN. Required: all outputs 0 immediately; after release, phase=0 and start with doorclose=0 is ignored.
